// File: rtl/ds_operand_stage.sv
// Decode-stage operand path: one valid/allowin pipeline slot that reads rs/rt,
// resolves them byte-lane by byte-lane through forwarding sources and a write-back bypass.
module ds_operand_stage #(
  parameter int NUM_FWD   = 2,
  parameter int PAYLOAD_W = 64,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [PAYLOAD_W-1:0]   in_payload,
  output logic                   in_allowin,
  output logic                   out_valid,
  input  logic                   out_allowin,
  output logic [PAYLOAD_W-1:0]   out_payload,
  output logic [31:0]            out_rs_value,
  output logic [31:0]            out_rt_value,
  input  logic                   flush,
  output logic [4:0]             rf_raddr1,
  output logic [4:0]             rf_raddr2,
  input  logic [31:0]            rf_rdata1,
  input  logic [31:0]            rf_rdata2,
  input  logic [3:0]             wb_we,
  input  logic [4:0]             wb_waddr,
  input  logic [31:0]            wb_wdata,
  input  logic [NUM_FWD*4-1:0]   fwd_we,
  input  logic [NUM_FWD*5-1:0]   fwd_dest,
  input  logic [NUM_FWD*32-1:0]  fwd_data,
  input  logic [NUM_FWD-1:0]     fwd_blk,
  output logic [CNT_W-1:0]       stall_cnt
);

  // Handshake: upstream transfers when in_valid && in_allowin; downstream transfers
  // when out_valid && out_allowin. A held instruction leaves only when not interlocked.
  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [4:0]           rs, rt;
  logic                 blocked, ready_go;

  // Instruction word sits in the top 32 bits of the payload.
  assign rs = payload_q[PAYLOAD_W-7 -: 5];
  assign rt = payload_q[PAYLOAD_W-12 -: 5];

  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  // Any blocking producer of rs/rt interlocks, regardless of younger matches.
  always_comb begin
    blocked = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (fwd_blk[i] && (fwd_dest[5*i +: 5] != 5'd0) &&
          ((fwd_dest[5*i +: 5] == rs) || (fwd_dest[5*i +: 5] == rt)))
        blocked = 1'b1;
    end
  end

  assign ready_go    = !blocked;
  assign in_allowin  = !valid_q || (ready_go && out_allowin);
  assign out_valid   = valid_q && ready_go && !flush;
  assign out_payload = payload_q;
  assign stall_cnt   = stall_cnt_q;

  function automatic logic [31:0] resolve_op(
    input logic [4:0]           r,
    input logic [31:0]          rf,
    input logic [NUM_FWD*4-1:0] f_we,
    input logic [NUM_FWD*5-1:0] f_dest,
    input logic [NUM_FWD*32-1:0] f_data,
    input logic [3:0]           w_we,
    input logic [4:0]           w_addr,
    input logic [31:0]          w_data
  );
    logic [31:0] v;
    logic        hit;
    v = rf;
    for (int l = 0; l < 4; l++) begin
      hit = 1'b0;
      if (r == 5'd0) begin
        v[8*l +: 8] = 8'h00;
      end else begin
        for (int i = 0; i < NUM_FWD; i++) begin
          if (!hit && f_we[4*i+l] && (f_dest[5*i +: 5] == r)) begin
            v[8*l +: 8] = f_data[32*i+8*l +: 8];
            hit         = 1'b1;
          end
        end
        if (!hit && w_we[l] && (w_addr == r))
          v[8*l +: 8] = w_data[8*l +: 8];
      end
    end
    return v;
  endfunction

  always_comb begin
    out_rs_value = resolve_op(rs, rf_rdata1, fwd_we, fwd_dest, fwd_data, wb_we, wb_waddr, wb_wdata);
    out_rt_value = resolve_op(rt, rf_rdata2, fwd_we, fwd_dest, fwd_data, wb_we, wb_waddr, wb_wdata);
  end

  always_comb begin
    valid_d     = valid_q;
    payload_d   = payload_q;
    stall_cnt_d = stall_cnt_q;
    if (flush)
      valid_d = 1'b0;
    else if (in_allowin)
      valid_d = in_valid;
    if (in_valid && in_allowin && !flush)
      payload_d = in_payload;
    // Saturating: sticks at all-ones rather than wrapping.
    if (valid_q && !ready_go && !flush && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    payload_q <= payload_d;
  end

endmodule

// File: tb/tb_ds_operand_stage.sv
// Bench for ds_operand_stage: directed scenarios then random traffic, checked by a
// scoreboard fed from a transaction-level model of the stage.
module tb_ds_operand_stage;
  localparam int NF = 2;
  localparam int PW = 64;
  localparam int CW = 5;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid, in_allowin, out_valid, out_allowin, flush;
  logic [PW-1:0]    in_payload, out_payload;
  logic [31:0]      out_rs_value, out_rt_value, rf_rdata1, rf_rdata2, wb_wdata;
  logic [4:0]       rf_raddr1, rf_raddr2, wb_waddr;
  logic [3:0]       wb_we;
  logic [NF*4-1:0]  fwd_we;
  logic [NF*5-1:0]  fwd_dest;
  logic [NF*32-1:0] fwd_data;
  logic [NF-1:0]    fwd_blk;
  logic [CW-1:0]    stall_cnt;

  logic [31:0] rf_mem [32];
  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  ds_operand_stage #(.NUM_FWD(NF), .PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_payload(in_payload),
    .in_allowin(in_allowin), .out_valid(out_valid), .out_allowin(out_allowin),
    .out_payload(out_payload), .out_rs_value(out_rs_value), .out_rt_value(out_rt_value),
    .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_we(wb_we), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .fwd_we(fwd_we), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .fwd_blk(fwd_blk), .stall_cnt(stall_cnt)
  );

  // reference model state
  logic          m_valid;
  logic [PW-1:0] m_payload;
  int            m_stall;
  logic          e_out_valid, e_in_allowin, chk_en;
  logic [CW-1:0] e_stall;
  logic [PW+63:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [4:0] m_rs();
    logic [31:0] inst;
    inst = m_payload[PW-1 -: 32];
    return inst[25:21];
  endfunction

  function automatic logic [4:0] m_rt();
    logic [31:0] inst;
    inst = m_payload[PW-1 -: 32];
    return inst[20:16];
  endfunction

  function automatic logic m_blocked();
    logic [4:0] d;
    for (int i = 0; i < NF; i++) begin
      d = fwd_dest[5*i +: 5];
      if (fwd_blk[i] && d != 0 && (d == m_rs() || d == m_rt())) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Replays writes oldest-first (RF, WB, then sources from oldest to youngest).
  function automatic logic [31:0] ref_operand(input logic [4:0] r);
    logic [31:0] v;
    if (r == 5'd0) return 32'h0;
    v = rf_mem[r];
    for (int l = 0; l < 4; l++)
      if (wb_we[l] && wb_waddr == r) v[8*l +: 8] = wb_wdata[8*l +: 8];
    for (int i = NF-1; i >= 0; i--)
      if (fwd_dest[5*i +: 5] == r)
        for (int l = 0; l < 4; l++)
          if (fwd_we[4*i+l]) v[8*l +: 8] = fwd_data[32*i+8*l +: 8];
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic idle();
    in_valid = 1'b0; in_payload = '0; flush = 1'b0; out_allowin = 1'b1;
    fwd_we = '0; fwd_dest = '0; fwd_data = '0; fwd_blk = '0;
    wb_we = '0; wb_waddr = '0; wb_wdata = '0;
  endtask

  task automatic set_fwd(input int i, input logic [4:0] d, input logic [3:0] we,
                         input logic [31:0] data, input logic blk);
    fwd_dest[5*i +: 5] = d;
    fwd_we[4*i +: 4]   = we;
    fwd_data[32*i +: 32] = data;
    fwd_blk[i]         = blk;
  endtask

  // Computes this cycle's expectations from the model, then advances it one edge.
  task automatic cycle();
    logic rg;
    rg = !m_blocked();
    e_in_allowin = !m_valid || (rg && out_allowin);
    e_out_valid  = m_valid && rg && !flush;
    e_stall      = m_stall[CW-1:0];
    if (!reset && e_out_valid && out_allowin)
      exp_q.push_back({m_payload, ref_operand(m_rs()), ref_operand(m_rt())});
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0;
      m_stall = 0;
    end else begin
      if (m_valid && !rg && !flush && m_stall < (1 << CW) - 1) m_stall++;
      if (flush) m_valid = 1'b0;
      else if (e_in_allowin) begin
        m_valid = in_valid;
        if (in_valid) m_payload = in_payload;
      end
    end
    #1;
  endtask

  task automatic load(input logic [31:0] inst);
    idle();
    in_valid = 1'b1;
    in_payload = {inst, 32'($urandom())};
    cycle();
    idle();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("out_valid", out_valid, e_out_valid);
      chk("in_allowin", in_allowin, e_in_allowin);
      chk("stall_cnt", stall_cnt, e_stall);
      if (m_valid) chk("out_payload_held", out_payload, m_payload);
      if (out_valid && out_allowin) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_issue: got payload %0h expected no issue", out_payload);
        end else begin
          logic [PW+63:0] e;
          e = exp_q.pop_front();
          chk("issue_payload", out_payload, e[PW+63 -: PW]);
          chk("rs_value", out_rs_value, e[63:32]);
          chk("rt_value", out_rt_value, e[31:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] inst;
    chk_en = 1'b0;
    m_valid = 1'b0; m_stall = 0; m_payload = '0;
    for (int r = 0; r < 32; r++) rf_mem[r] = $urandom();
    rf_mem[1] = 32'd5;
    rf_mem[2] = 32'd7;
    idle();
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    chk_en = 1'b1;

    // add $3,$1,$2 with plain RF reads
    load(32'h00221820);
    cycle();
    // source 0 wins over source 1
    load(32'h00221820);
    set_fwd(0, 5'd1, 4'hF, 32'hAAAA0000, 1'b0);
    set_fwd(1, 5'd1, 4'hF, 32'h11111111, 1'b0);
    cycle();
    // byte-lane merge of forward and write-back
    load(32'h00221820);
    set_fwd(0, 5'd2, 4'h1, 32'h000000CC, 1'b0);
    wb_we = 4'hF; wb_waddr = 5'd2; wb_wdata = 32'h12345678;
    cycle();
    // older blocking source interlocks despite younger match
    load(32'h00221820);
    set_fwd(1, 5'd1, 4'hF, 32'hDEADBEEF, 1'b1);
    set_fwd(0, 5'd1, 4'hF, 32'h01020304, 1'b0);
    in_valid = 1'b1; in_payload = {32'h00431820, 32'h0};
    repeat (3) cycle();
    idle();
    cycle();
    // $0 never forwards nor stalls
    load(32'h00051820);
    set_fwd(0, 5'd0, 4'hF, 32'hFFFFFFFF, 1'b1);
    cycle();
    // flush while stalled with incoming instruction
    load(32'h00221820);
    set_fwd(1, 5'd2, 4'hF, 32'h0, 1'b1);
    cycle();
    flush = 1'b1; in_valid = 1'b1; in_payload = {32'h00431820, 32'h5};
    cycle();
    idle();
    cycle();
    // downstream backpressure holds payload
    load(32'h00221820);
    out_allowin = 1'b0; in_valid = 1'b1; in_payload = {32'h00431820, 32'h9};
    repeat (2) cycle();
    idle();
    cycle();
    // long stall saturates, then reset mid-stall
    load(32'h00221820);
    set_fwd(0, 5'd1, 4'hF, 32'h0, 1'b1);
    repeat (40) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle();
    repeat (2) cycle();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      inst = $urandom();
      inst[25:21] = 5'($urandom_range(0, 3));
      inst[20:16] = 5'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
      in_payload = {inst, 32'($urandom())};
      flush = ($urandom_range(0, 15) == 0);
      out_allowin = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NF; i++)
        set_fwd(i, 5'($urandom_range(0, 3)), 4'($urandom()), $urandom(),
                ($urandom_range(0, 7) == 0));
      wb_we = 4'($urandom());
      wb_waddr = 5'($urandom_range(0, 3));
      wb_wdata = $urandom();
      cycle();
    end
    idle();
    repeat (3) cycle();
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ds_operand_stage.md
Name: ds_operand_stage

Overview:
- Parametrised successor to the decode-stage operand path. Holds one instruction in a valid/allowin pipeline register and reads rs/rt from the register file.
- Resolves rs/rt values through NUM_FWD prioritised, byte-lane-granular forwarding sources plus a write-back bypass.
- Interlocks on blocking producers (loads in flight, multi-cycle ops). Supports flush and keeps a saturating stall counter for performance monitoring.

Parameters:
NUM_FWD, 2, number of forwarding sources; index 0 = youngest and highest priority (EX), then MEM, and so on
PAYLOAD_W, 64, stage payload width; payload[PAYLOAD_W-1 -: 32] is the instruction word, the rest is opaque and passed through
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  upstream valid
in_payload  in  PAYLOAD_W  upstream payload
in_allowin  out  1  stage can accept
out_valid  out  1  downstream valid
out_allowin  in  1  downstream can accept
out_payload  out  PAYLOAD_W  held payload
out_rs_value  out  32  resolved rs operand
out_rt_value  out  32  resolved rt operand
flush  in  1  kill held instruction
rf_raddr1  out  5  rs = inst[25:21]
rf_raddr2  out  5  rt = inst[20:16]
rf_rdata1  in  32  register file read data, port 1
rf_rdata2  in  32  register file read data, port 2
wb_we  in  4  write-back byte enables
wb_waddr  in  5  write-back address
wb_wdata  in  32  write-back data
fwd_we  in  NUM_FWD*4  per-source byte-lane valid; source i occupies bits [4i+3:4i]
fwd_dest  in  NUM_FWD*5  per-source destination register
fwd_data  in  NUM_FWD*32  per-source result data
fwd_blk  in  NUM_FWD  source i writes fwd_dest[i] but its data is not yet available
stall_cnt  out  CNT_W  cycles spent valid and interlocked

Behaviour:
- Reset: valid=0, stall_cnt=0, out_valid=0, in_allowin=1. The payload register is don't-care.
- ready_go = !blocked.
  - blocked = OR over i of fwd_blk[i] && fwd_dest[i]!=0 && (fwd_dest[i]==rs || fwd_dest[i]==rt).
  - A blocking source interlocks even when a younger source also matches.
- in_allowin = !valid || (ready_go && out_allowin).
- out_valid = valid && ready_go && !flush.
- Sequential update:
  - flush: valid<=0 (has priority over load).
  - else if in_allowin: valid<=in_valid.
  - Payload is loaded when in_valid && in_allowin && !flush.
- Operand resolution is combinational from the held payload, with zero added latency. For each operand reg and each byte lane L (0..3):
  - reg==0: lane is 0; no forwarding or bypass for $0.
  - else the lowest i with fwd_we[i][L] && fwd_dest[i]==reg supplies fwd_data[i] lane L.
  - else wb_we[L] && wb_waddr==reg supplies wb_wdata lane L.
  - else the rf_rdata lane.
  - Lanes resolve independently, so partial writes (lwl/lwr, sb) merge across sources.
- stall_cnt:
  - increments by 1 each cycle that valid && !ready_go && !flush.
  - saturates at all-ones; never wraps.
  - cleared only by reset.
- Simultaneous flush and in_valid: the incoming instruction is dropped.
- Reset asserted mid-stall: valid and stall_cnt are cleared on the next edge.

Test Plan:
- Reset, then in_valid=1 with inst 0x00221820 (add $3,$1,$2), rf_rdata1=5, rf_rdata2=7, no forwards → out_valid next cycle, rs=5, rt=7, in_allowin=1.
- fwd0 dest=1, we=4'hF, data=0xAAAA0000; fwd1 dest=1, we=4'hF, data=0x11111111 → rs=0xAAAA0000 (source 0 wins).
- fwd0 dest=2, we=4'h1, data=0x000000CC; wb waddr=2, we=4'hF, wdata=0x12345678 → rt=0x123456CC.
- fwd_blk[1]=1, dest=1 for 3 cycles, with fwd0 also matching → out_valid=0 and in_allowin=0 for 3 cycles, stall_cnt=3, then the instruction issues.
- inst with rs=$0 while fwd0 dest=0, we=4'hF, blk=1 → no stall, rs=0.
- flush while stalled with in_valid=1 → valid=0 next cycle, no output, stall_cnt holds; out_allowin=0 with ready_go=1 → payload held stable and in_allowin=0.
